// File: rtl/i2c_seq_pkg.sv
// Shared types for the i2c command sequencer: FSM states and the
// command/response records carried through the two FIFOs.
package i2c_seq_pkg;

    localparam int ADDR_W = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EN,
        S_WAIT_RISE,
        S_WAIT,
        S_GAP,
        S_RESP
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              rw;
        logic [7:0]        wdata;
    } cmd_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        logic              timeout;
    } rsp_t;

endpackage

// File: rtl/i2c_sync_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers. A push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module i2c_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head reads as zero when empty so downstream outputs are clean after reset.
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Feeds queued host transactions to an i2c_master one at a time, holds en for a
// fixed window, tracks busy, enforces an inter-transaction gap, returns read data.
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int EN_HOLD   = 250,
    parameter int GAP_CYC   = 250,
    parameter int BUSY_TO   = 1000
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_rw,
    input  logic [7:0]        cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] m_addr,
    output logic [7:0]        m_data_in,
    output logic              m_rw,
    output logic              m_en,
    input  logic              m_busy,
    input  logic [7:0]        m_data_out,
    output logic              idle,
    output logic              err_to,
    output state_t            state_dbg
);

    localparam int CNT_MAX = (GAP_CYC > BUSY_TO) ? GAP_CYC : BUSY_TO;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(EN_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(BUSY_TO - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] to_cnt;
    logic             busy_seen;
    logic             timed_out;
    logic [7:0]       rdata_q;

    cmd_t cmd_in, cmd_head;
    rsp_t rsp_in, rsp_head;
    logic cmd_full, cmd_empty, cmd_pop;
    logic rsp_full, rsp_empty, rsp_push, rsp_pop;
    logic rsp_room, to_fire;

    assign cmd_in = '{addr: cmd_addr, rw: cmd_rw, wdata: cmd_wdata};
    assign rsp_in = '{addr: m_addr, data: (timed_out ? 8'h00 : rdata_q), timeout: timed_out};

    i2c_sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .arst_n  (arst_n),
        .push    (cmd_valid),
        .wr_data (cmd_in),
        .pop     (cmd_pop),
        .rd_data (cmd_head),
        .full    (cmd_full),
        .empty   (cmd_empty)
    );

    i2c_sync_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk     (clk),
        .arst_n  (arst_n),
        .push    (rsp_push),
        .wr_data (rsp_in),
        .pop     (rsp_pop),
        .rd_data (rsp_head),
        .full    (rsp_full),
        .empty   (rsp_empty)
    );

    assign cmd_ready   = !cmd_full;
    assign rsp_valid   = !rsp_empty;
    assign rsp_pop     = rsp_valid && rsp_ready;
    assign rsp_room    = !rsp_full || rsp_pop;
    assign rsp_addr    = rsp_head.addr;
    assign rsp_data    = rsp_head.data;
    assign rsp_timeout = rsp_head.timeout;
    assign idle        = cmd_empty && (state_q == S_IDLE);
    assign state_dbg   = state_q;

    always_comb begin
        state_d  = state_q;
        cmd_pop  = 1'b0;
        rsp_push = 1'b0;
        to_fire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!cmd_empty) begin
                    cmd_pop = 1'b1;
                    state_d = S_EN;
                end
            end
            S_EN: begin
                // A transfer shorter than the hold window can already be over here.
                if (hold_cnt == HOLD_LAST) begin
                    if (m_busy)         state_d = S_WAIT;
                    else if (busy_seen) state_d = S_GAP;
                    else                state_d = S_WAIT_RISE;
                end
            end
            S_WAIT_RISE: begin
                if (m_busy) begin
                    state_d = S_WAIT;
                end else if (to_cnt == TO_LAST) begin
                    to_fire = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                if (!m_busy) state_d = S_GAP;
            end
            S_GAP: begin
                if (hold_cnt == GAP_LAST) state_d = S_RESP;
            end
            S_RESP: begin
                if (!m_rw) begin
                    state_d = S_IDLE;
                end else if (rsp_room) begin
                    rsp_push = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= S_IDLE;
            m_en      <= 1'b0;
            m_addr    <= '0;
            m_data_in <= '0;
            m_rw      <= 1'b0;
            hold_cnt  <= '0;
            to_cnt    <= '0;
            busy_seen <= 1'b0;
            timed_out <= 1'b0;
            rdata_q   <= '0;
            err_to    <= 1'b0;
        end else begin
            state_q <= state_d;
            m_en    <= (state_d == S_EN);
            if (cmd_pop) begin
                m_addr    <= cmd_head.addr;
                m_rw      <= cmd_head.rw;
                m_data_in <= cmd_head.rw ? 8'h00 : cmd_head.wdata;
                hold_cnt  <= '0;
                to_cnt    <= '0;
                busy_seen <= 1'b0;
                timed_out <= 1'b0;
                rdata_q   <= '0;
            end
            if (state_q == S_EN || state_q == S_WAIT_RISE) to_cnt <= to_cnt + CNT_W'(1);
            if (state_q == S_EN) begin
                hold_cnt <= hold_cnt + CNT_W'(1);
                if (m_busy) busy_seen <= 1'b1;
            end
            // hold_cnt is reused as the gap counter; read data is captured as busy ends.
            if (state_d == S_GAP && state_q != S_GAP) begin
                hold_cnt <= '0;
                rdata_q  <= m_data_out;
            end else if (state_q == S_GAP) begin
                hold_cnt <= hold_cnt + CNT_W'(1);
            end
            if (to_fire) begin
                timed_out <= 1'b1;
                err_to    <= 1'b1;
            end
        end
    end

endmodule
